// File: rtl/sw_input_port.sv
// sw_input_port: debounced active-low switch inputs with sticky press flags and a press counter
module sw_input_port #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  switch_1,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata
);
    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);
    logic [7:0]  r_s1, r_s2, r_cand, r_stable, r_edge;
    logic [19:0] r_cnt;
    logic [15:0] r_pcnt;
    logic        w_accept, w_cnt_wr, w_unused;
    logic [7:0]  w_rise, w_clr;
    logic [3:0]  w_pop;
    logic [16:0] w_sum;
    assign w_accept = r_s2 == r_cand && r_cnt == CNT_LAST && r_cand != r_stable;
    assign w_rise   = w_accept ? r_cand & ~r_stable : 8'h00;
    assign w_clr    = data_sram_we && data_sram_addr == 32'h0000_0408 ? data_sram_wdata[7:0] : 8'h00;
    assign w_cnt_wr = data_sram_we && data_sram_addr == 32'h0000_040C;
    assign w_pop    = 4'($countones(w_rise));
    // a counter write clears first, then this cycle's presses are added
    assign w_sum    = {1'b0, w_cnt_wr ? 16'h0000 : r_pcnt} + {13'b0, w_pop};
    assign w_unused = ^data_sram_wdata[31:8];
    // two-flop synchronizer, inverting so that 1 means pressed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1 <= 8'h00;
            r_s2 <= 8'h00;
        end else begin
            r_s1 <= ~switch_1;
            r_s2 <= r_s1;
        end
    end
    // whole-vector debounce: count consecutive cycles the synchronized vector stays unchanged
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cand <= 8'h00;
            r_cnt  <= 20'h0;
        end else begin
            r_cand <= r_s2;
            r_cnt  <= r_s2 != r_cand ? 20'h0 : r_cnt != CNT_LAST ? r_cnt + 20'h1 : r_cnt;
        end
    end
    // accepted vector, sticky press flags (set beats clear) and saturating press count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stable <= 8'h00;
            r_edge   <= 8'h00;
            r_pcnt   <= 16'h0000;
        end else begin
            r_stable <= w_accept ? r_cand : r_stable;
            r_edge   <= (r_edge & ~w_clr) | w_rise;
            r_pcnt   <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end
    // same-cycle register read decode, full address compare
    always_comb begin
        data_sram_rdata = data_sram_addr == 32'h0000_0400 ? {24'h0, r_stable} :
                          data_sram_addr == 32'h0000_0408 ? {24'h0, r_edge} :
                          data_sram_addr == 32'h0000_040C ? {16'h0, r_pcnt} : 32'h0;
    end
endmodule

// File: tb/tb_sw_input_port.sv
// tb_sw_input_port: directed tables plus randomized run against a history-based reference model
module tb_sw_input_port;
    localparam int D = 4;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  sw = 8'hFF;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    int checks = 0;
    int passes = 0;
    logic [7:0]  m_stable, m_edge, m_pprev;
    logic [15:0] m_pcnt;
    logic [7:0]  m_hist[$];

    sw_input_port #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .resetn(resetn), .switch_1(sw), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  sw;
        int          hold;
        logic [7:0]  st;
        logic [7:0]  ed;
        logic [15:0] cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic model_init();
        m_stable = 8'h00;
        m_edge = 8'h00;
        m_pcnt = 16'h0000;
        m_pprev = 8'h00;
        m_hist = {8'h00, 8'h00};
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return a == 32'h400 ? {24'h0, m_stable} : a == 32'h408 ? {24'h0, m_edge} :
               a == 32'h40C ? {16'h0, m_pcnt} : 32'h0;
    endfunction

    // a vector is accepted once the synchronized value has been the same for D+1 samples
    task automatic model_step();
        logic acc;
        logic [7:0] v, rise, clr;
        int base;
        v = m_hist[m_hist.size() - 1];
        acc = m_hist.size() == D + 1 && v != m_stable;
        foreach (m_hist[i]) if (m_hist[i] != v) acc = 1'b0;
        rise = acc ? v & ~m_stable : 8'h00;
        clr = (we && addr == 32'h408) ? wdata[7:0] : 8'h00;
        m_edge = (m_edge & ~clr) | rise;
        base = (we && addr == 32'h40C) ? 0 : int'(m_pcnt);
        base += $countones(rise);
        m_pcnt = base > 65535 ? 16'hFFFF : 16'(base);
        if (acc) m_stable = v;
        m_hist.push_back(m_pprev);
        if (m_hist.size() > D + 1) void'(m_hist.pop_front());
        m_pprev = ~sw;
    endtask

    task automatic tick();
        if (resetn) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_init();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic rd(input logic [31:0] a, input string name, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1;
        addr = a;
        wdata = d;
        tick();
        we = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        sw = v;
        repeat (n) tick();
    endtask

    initial begin
        vec_t tbl[8];
        logic [31:0] amap[6];
        tbl[0] = '{8'hF6, 3,  8'h01, 8'h01, 16'd1};
        tbl[1] = '{8'hFE, 10, 8'h01, 8'h01, 16'd1};
        tbl[2] = '{8'hF6, 4,  8'h01, 8'h01, 16'd1};
        tbl[3] = '{8'hFE, 10, 8'h01, 8'h01, 16'd1};
        tbl[4] = '{8'hF6, 6,  8'h01, 8'h01, 16'd1};
        tbl[5] = '{8'hFE, 10, 8'h01, 8'h09, 16'd2};
        tbl[6] = '{8'hF0, 10, 8'h0F, 8'h0F, 16'd5};
        tbl[7] = '{8'hFF, 10, 8'h00, 8'h0F, 16'd5};
        amap = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410, 32'h8000_0408};

        sw = 8'h00;
        model_init();
        repeat (2) @(posedge clk);
        #1;
        rd(32'h400, "in_reset_state", 32'h0);
        rd(32'h40C, "in_reset_cnt", 32'h0);
        do_reset();
        for (int k = 0; k < 7; k++) begin
            rd(32'h400, "rst_state", 32'h0);
            rd(32'h408, "rst_edge", 32'h0);
            rd(32'h40C, "rst_cnt", 32'h0);
            tick();
        end
        rd(32'h400, "rst_acc_state", 32'hFF);
        rd(32'h408, "rst_acc_edge", 32'hFF);
        rd(32'h40C, "rst_acc_cnt", 32'd8);

        hold(8'hFF, 10);
        wr(32'h408, 32'hFF);
        wr(32'h40C, 32'h0);
        rd(32'h400, "idle_state", 32'h0);
        rd(32'h408, "idle_edge", 32'h0);
        rd(32'h40C, "idle_cnt", 32'h0);

        sw = 8'hFE;
        for (int k = 1; k < 7; k++) begin
            tick();
            rd(32'h400, "press_wait", 32'h0);
        end
        tick();
        rd(32'h400, "press_state", 32'h01);
        rd(32'h408, "press_edge", 32'h01);
        rd(32'h40C, "press_cnt", 32'd1);

        for (int i = 0; i < 8; i++) begin
            hold(tbl[i].sw, tbl[i].hold);
            rd(32'h400, $sformatf("tbl%0d_state", i), {24'h0, tbl[i].st});
            rd(32'h408, $sformatf("tbl%0d_edge", i), {24'h0, tbl[i].ed});
            rd(32'h40C, $sformatf("tbl%0d_cnt", i), {16'h0, tbl[i].cnt});
        end

        wr(32'h408, 32'h0A);
        rd(32'h408, "w1c_prep", 32'h05);
        wr(32'h408, 32'hFFFF_FF04);
        rd(32'h408, "w1c_clear", 32'h01);
        wr(32'h408, 32'h01);
        rd(32'h408, "w1c_empty", 32'h00);
        hold(8'hFE, 6);
        wr(32'h408, 32'h01);
        rd(32'h408, "w1c_set_wins", 32'h01);
        rd(32'h400, "w1c_state", 32'h01);

        hold(8'hFF, 10);
        force dut.r_pcnt = 16'hFFFD;
        #1;
        release dut.r_pcnt;
        m_pcnt = 16'hFFFD;
        rd(32'h40C, "cnt_preload", 32'hFFFD);
        hold(8'hF0, 10);
        rd(32'h40C, "cnt_saturate", 32'hFFFF);
        hold(8'hFF, 10);
        rd(32'h40C, "cnt_hold_sat", 32'hFFFF);
        hold(8'hFC, 6);
        wr(32'h40C, 32'h1234_5678);
        rd(32'h40C, "cnt_clr_add", 32'd2);
        rd(32'h400, "cnt_state", 32'h03);

        rd(32'h404, "dec_404", 32'h0);
        rd(32'h410, "dec_410", 32'h0);
        rd(32'h8000_0400, "dec_hi400", 32'h0);
        rd(32'h8000_0408, "dec_hi408", 32'h0);
        wr(32'h400, 32'hFF);
        rd(32'h400, "dec_ro_state", 32'h03);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            if ($urandom_range(0, 5) == 0) sw = 8'($urandom);
            we = $urandom_range(0, 5) == 0;
            addr = amap[$urandom_range(0, 5)];
            wdata = $urandom;
            #1;
            check($sformatf("rand_rd_%0h", addr), rdata, model_read(addr));
            tick();
        end
        we = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
